// File: rtl/uart_frame_rx.sv
// UART 8N1 receiver that assembles HEADER + PAYLOAD_BYTES into one frame word with valid/ready handoff.
// Optional FRAME_CHECKSUM_EN: a trailing byte (HEADER ^ payload bytes) must match or the frame is dropped.
module uart_frame_rx #(
  parameter int          CLKS_PER_BIT   = 10416,
  parameter logic [7:0]  HEADER         = 8'h01,
  parameter int          PAYLOAD_BYTES  = 32,
  parameter int          TIMEOUT_CYCLES = 208320
) (
  input  logic                       CLK,
  input  logic                       NRST,
  input  logic                       RX_UART,
  output logic [8*PAYLOAD_BYTES-1:0] frame_data,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic                       BSY,
  output logic                       err_framing,
  output logic                       err_timeout,
`ifdef FRAME_CHECKSUM_EN
  output logic                       err_checksum,
`endif
  output logic                       err_overrun
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int DW = 8 * PAYLOAD_BYTES;
  localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL     = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES - 1);

  logic rx_meta, rxs;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RX_UART;
      rxs     <= rx_meta;
    end
  end

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_t;

  rx_state_t     rx_state, rx_state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          byte_done, byte_done_nxt;
  logic          framing_nxt;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      rx_state    <= R_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      byte_done   <= 1'b0;
      err_framing <= 1'b0;
    end else begin
      rx_state    <= rx_state_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shreg       <= shreg_nxt;
      byte_done   <= byte_done_nxt;
      err_framing <= framing_nxt;
    end
  end

  always_comb begin
    rx_state_nxt  = rx_state;
    cnt_nxt       = cnt + 1'b1;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    byte_done_nxt = 1'b0;
    framing_nxt   = 1'b0;
    case (rx_state)
      R_IDLE: begin
        cnt_nxt     = '0;
        bit_idx_nxt = '0;
        if (!rxs) rx_state_nxt = R_START;
      end
      R_START: begin
        // Re-check mid start bit so short low glitches are rejected.
        if (cnt == HALF) begin
          cnt_nxt      = '0;
          rx_state_nxt = rxs ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (cnt == FULL) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rxs, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_nxt = R_STOP;
        end
      end
      R_STOP: begin
        if (cnt == FULL) begin
          cnt_nxt = '0;
          if (rxs) begin
            byte_done_nxt = 1'b1;
            rx_state_nxt  = R_IDLE;
          end else begin
            framing_nxt  = 1'b1;
            rx_state_nxt = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        cnt_nxt = '0;
        if (rxs) rx_state_nxt = R_IDLE;
      end
      default: rx_state_nxt = R_IDLE;
    endcase
  end

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {F_HDR, F_PAY, F_CHK, F_HOLD} fr_state_t;
  logic [7:0] csum, csum_nxt;
  logic       err_checksum_nxt;
`else
  typedef enum logic [1:0] {F_HDR, F_PAY, F_HOLD} fr_state_t;
`endif

  fr_state_t     fr_state, fr_state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [DW-1:0] data_nxt;
  logic          valid_nxt, bsy_nxt, timeout_nxt, overrun_nxt;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(timer) + 32'd1) >= 32'(TIMEOUT_CYCLES));

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      fr_state     <= F_HDR;
      idx          <= '0;
      timer        <= '0;
      frame_data   <= '0;
      frame_valid  <= 1'b0;
      BSY          <= 1'b0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      csum         <= '0;
      err_checksum <= 1'b0;
`endif
    end else begin
      fr_state     <= fr_state_nxt;
      idx          <= idx_nxt;
      timer        <= timer_nxt;
      frame_data   <= data_nxt;
      frame_valid  <= valid_nxt;
      BSY          <= bsy_nxt;
      err_timeout  <= timeout_nxt;
      err_overrun  <= overrun_nxt;
`ifdef FRAME_CHECKSUM_EN
      csum         <= csum_nxt;
      err_checksum <= err_checksum_nxt;
`endif
    end
  end

  always_comb begin
    fr_state_nxt     = fr_state;
    idx_nxt          = idx;
    timer_nxt        = timer;
    data_nxt         = frame_data;
    valid_nxt        = frame_valid;
    bsy_nxt          = BSY;
    timeout_nxt      = 1'b0;
    overrun_nxt      = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    csum_nxt         = csum;
    err_checksum_nxt = 1'b0;
`endif
    case (fr_state)
      F_HDR: begin
        if (byte_done && shreg == HEADER) begin
          fr_state_nxt = F_PAY;
          idx_nxt      = '0;
          timer_nxt    = '0;
          bsy_nxt      = 1'b1;
`ifdef FRAME_CHECKSUM_EN
          csum_nxt     = HEADER;
`endif
        end
      end
      F_PAY: begin
        if (err_framing) begin
          fr_state_nxt = F_HDR;
          idx_nxt      = '0;
          bsy_nxt      = 1'b0;
        end else if (byte_done) begin
          data_nxt  = (frame_data << 8) | DW'(shreg);
          timer_nxt = '0;
          idx_nxt   = idx + 1'b1;
`ifdef FRAME_CHECKSUM_EN
          csum_nxt  = csum ^ shreg;
`endif
          if (idx == LAST_IDX) begin
            idx_nxt = '0;
`ifdef FRAME_CHECKSUM_EN
            fr_state_nxt = F_CHK;
`else
            fr_state_nxt = F_HOLD;
            valid_nxt    = 1'b1;
`endif
          end
        end else if (timeout_hit) begin
          timeout_nxt  = 1'b1;
          fr_state_nxt = F_HDR;
          idx_nxt      = '0;
          bsy_nxt      = 1'b0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
`ifdef FRAME_CHECKSUM_EN
      F_CHK: begin
        if (err_framing) begin
          fr_state_nxt = F_HDR;
          bsy_nxt      = 1'b0;
        end else if (byte_done) begin
          if (shreg == csum) begin
            fr_state_nxt = F_HOLD;
            valid_nxt    = 1'b1;
          end else begin
            err_checksum_nxt = 1'b1;
            fr_state_nxt     = F_HDR;
            bsy_nxt          = 1'b0;
          end
        end else if (timeout_hit) begin
          timeout_nxt  = 1'b1;
          fr_state_nxt = F_HDR;
          bsy_nxt      = 1'b0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
`endif
      F_HOLD: begin
        // Bytes arriving while the frame is parked are lost, headers included.
        if (byte_done) overrun_nxt = 1'b1;
        if (frame_valid && frame_ready) begin
          valid_nxt    = 1'b0;
          bsy_nxt      = 1'b0;
          fr_state_nxt = F_HDR;
        end
      end
      default: fr_state_nxt = F_HDR;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: serial byte driver, queue scoreboard checked at each frame handshake.
module tb_uart_frame_rx;
  localparam int         CPB = 16;
  localparam int         P   = 32;
  localparam int         TO  = 400;
  localparam int         DW  = 8 * P;
  localparam logic [7:0] HDR = 8'h01;

  logic          CLK = 1'b0;
  logic          NRST = 1'b0;
  logic          RX_UART = 1'b1;
  logic          frame_ready = 1'b0;
  logic [DW-1:0] frame_data;
  logic          frame_valid, BSY, err_framing, err_timeout, err_overrun;
`ifdef FRAME_CHECKSUM_EN
  logic          err_checksum;
`endif

  always #5 CLK = ~CLK;

  uart_frame_rx #(
    .CLKS_PER_BIT(CPB), .HEADER(HDR), .PAYLOAD_BYTES(P), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .NRST(NRST), .RX_UART(RX_UART),
    .frame_data(frame_data), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .BSY(BSY), .err_framing(err_framing), .err_timeout(err_timeout),
`ifdef FRAME_CHECKSUM_EN
    .err_checksum(err_checksum),
`endif
    .err_overrun(err_overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_ferr = 0, n_terr = 0, n_oerr = 0, n_bytes = 0;
  logic [DW-1:0] exp_q[$];
  logic hs_prev = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!NRST) begin
      hs_prev = 1'b0;
    end else begin
      if (hs_prev) begin
        check("post_hs_valid", frame_valid, 0);
        check("post_hs_bsy", BSY, 0);
      end
      hs_prev = frame_valid && frame_ready;
      if (frame_valid && frame_ready) begin
        if (exp_q.size() == 0) check("unexpected_frame", frame_valid, 0);
        else check("frame_data", frame_data, exp_q.pop_front());
      end
      n_ferr  += int'(err_framing);
      n_terr  += int'(err_timeout);
      n_oerr  += int'(err_overrun);
      n_bytes += int'(dut.byte_done);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RX_UART = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RX_UART = b[i];
      tick(CPB);
    end
    RX_UART = stop;
    tick(CPB);
    if (stop) tick(4);
  endtask

  task automatic send_frame(input logic [DW-1:0] pay);
    logic [7:0] cs;
    cs = HDR;
    exp_q.push_back(pay);
    send_byte(HDR, 1'b1);
    for (int i = 0; i < P; i++) begin
      cs = cs ^ pay[DW-1-8*i -: 8];
      send_byte(pay[DW-1-8*i -: 8], 1'b1);
    end
`ifdef FRAME_CHECKSUM_EN
    send_byte(cs, 1'b1);
`endif
  endtask

  function automatic logic [DW-1:0] rand_frame();
    logic [DW-1:0] v;
    for (int i = 0; i < P; i++) v[8*i +: 8] = 8'($urandom_range(0, 255));
    return v;
  endfunction

  initial begin
    logic [DW-1:0] v;
    int f0, t0, o0, b0;

    tick(5);
    @(negedge CLK);
    check("rst_data", frame_data, 0);
    check("rst_flags", {frame_valid, BSY, err_framing, err_timeout, err_overrun}, 0);
    NRST = 1'b1;
    tick(20);

    // Known-pattern frame, consumer always ready
    frame_ready = 1'b1;
    b0 = n_bytes;
    send_frame(256'h00112233445566778899AABBCCDDEEFF000102030405060708090A0B0C0D0E0F);
    tick(20);
    check("t1_drained", exp_q.size(), 0);
    check("t1_bsy", BSY, 0);
    check("t1_bytes", n_bytes - b0, P + 1);
    check("t1_errs", n_ferr + n_terr + n_oerr, 0);

    // Junk bytes before the header are ignored
    send_byte(8'h55, 1'b1);
    send_byte(8'h7E, 1'b1);
    tick(2);
    check("t2_bsy_idle", BSY, 0);
    send_frame(rand_frame());
    tick(20);
    check("t2_drained", exp_q.size(), 0);
    check("t2_errs", n_ferr + n_terr + n_oerr, 0);

    // Inter-byte timeout aborts a partial frame
    t0 = n_terr;
    send_byte(HDR, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    check("t3_bsy_busy", BSY, 1);
    tick(TO + 200);
    check("t3_timeout", n_terr - t0, 1);
    check("t3_bsy", BSY, 0);
    check("t3_valid", frame_valid, 0);
    send_frame(rand_frame());
    tick(20);
    check("t3_drained", exp_q.size(), 0);

    // Framing error mid-payload, then line held low
    f0 = n_ferr; t0 = n_terr; b0 = n_bytes;
    send_byte(HDR, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    send_byte(8'hC3, 1'b0);
    tick(100);
    RX_UART = 1'b1;
    tick(20);
    check("t4_framing", n_ferr - f0, 1);
    check("t4_timeout", n_terr - t0, 0);
    check("t4_bsy", BSY, 0);
    check("t4_bytes", n_bytes - b0, 4);
    send_frame(rand_frame());
    tick(20);
    check("t4_drained", exp_q.size(), 0);

    // Overrun while the frame is held
    frame_ready = 1'b0;
    o0 = n_oerr;
    v = rand_frame();
    send_frame(v);
    tick(5);
    check("t5_valid", frame_valid, 1);
    check("t5_bsy", BSY, 1);
    check("t5_data_held", frame_data, v);
    send_byte(8'hAA, 1'b1);
    tick(5);
    check("t5_overrun", n_oerr - o0, 1);
    check("t5_data_kept", frame_data, v);
    check("t5_valid_kept", frame_valid, 1);
    frame_ready = 1'b1;
    tick(3);
    check("t5_drained", exp_q.size(), 0);
    check("t5_valid_low", frame_valid, 0);

    // Short glitch, then reset mid-payload
    f0 = n_ferr; t0 = n_terr; o0 = n_oerr; b0 = n_bytes;
    RX_UART = 1'b0;
    tick(6);
    RX_UART = 1'b1;
    tick(60);
    check("t6_glitch_bytes", n_bytes - b0, 0);
    check("t6_glitch_errs", (n_ferr - f0) + (n_terr - t0) + (n_oerr - o0), 0);
    check("t6_glitch_bsy", BSY, 0);
    send_byte(HDR, 1'b1);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(1, 255)), 1'b1);
    check("t6_bsy_busy", BSY, 1);
    NRST = 1'b0;
    tick(2);
    @(negedge CLK);
    check("t6_rst_data", frame_data, 0);
    check("t6_rst_flags", {frame_valid, BSY, err_framing, err_timeout, err_overrun}, 0);
    NRST = 1'b1;
    tick(10);
    send_frame(rand_frame());
    tick(20);
    check("t6_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
